// File: rtl/spi_cs_router.sv
// Host SPI command router: the first byte of a frame selects one of NUM_DEV
// downstream devices, the remainder is forwarded to it and captured locally.
module spi_cs_router #(
    parameter int                 NUM_DEV     = 4,
    parameter logic [NUM_DEV-1:0] LDAC_MASK   = NUM_DEV'(4'b0010),
    parameter int                 LDAC_CYCLES = 4,
    parameter int                 GAP_CYCLES  = 2,
    parameter int                 CAP_W       = 32
) (
    input  logic               clk_in,
    input  logic               sys_rstn,
    input  logic               host_ss,
    input  logic               host_sclk,
    input  logic               host_mosi,
    output logic               host_miso,
    output logic [NUM_DEV-1:0] dev_cs_n,
    output logic               dev_sck,
    output logic               dev_mosi,
    input  logic [NUM_DEV-1:0] dev_miso,
    output logic [NUM_DEV-1:0] dev_ldac_n,
    output logic               cap_valid,
    output logic [7:0]         cap_dev,
    output logic [CAP_W-1:0]   cap_mosi,
    output logic [CAP_W-1:0]   cap_miso,
    output logic [15:0]        cap_bits,
    output logic               cmd_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CMD    = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] DROP   = 3'd3;
    localparam logic [2:0] ACTIVE = 3'd4;
    localparam logic [2:0] LDAC   = 3'd5;
    localparam logic [2:0] GAP    = 3'd6;

    logic [2:0]         ss_pipe, sclk_pipe;
    logic [1:0]         mosi_pipe;
    logic [2:0]         state;
    logic [2:0]         cmd_cnt;
    logic [7:0]         cmd_sr;
    logic [15:0]        cnt;
    logic [NUM_DEV-1:0] sel_oh;
    logic [CAP_W-1:0]   sh_mosi, sh_miso;
    logic [15:0]        sh_bits;
    logic               frame_done, err_q, active;

    // Index 1 is the synchronised value, index 2 the history used for edge detection.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            ss_pipe   <= 3'b111;
            sclk_pipe <= 3'b000;
            mosi_pipe <= 2'b00;
        end else begin
            ss_pipe   <= {ss_pipe[1:0], host_ss};
            sclk_pipe <= {sclk_pipe[1:0], host_sclk};
            mosi_pipe <= {mosi_pipe[0], host_mosi};
        end
    end

    wire ss_fall   =  ss_pipe[2]   & ~ss_pipe[1];
    wire ss_rise   = ~ss_pipe[2]   &  ss_pipe[1];
    wire sck_rise  = ~sclk_pipe[2] &  sclk_pipe[1];
    wire sck_fall  =  sclk_pipe[2] & ~sclk_pipe[1];
    wire mosi_s    =  mosi_pipe[1];
    wire code_ok   = (cmd_sr != 8'd0) && (int'(cmd_sr) <= NUM_DEV);
    wire miso_sel  = |(dev_miso & sel_oh);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state      <= IDLE;
            cmd_cnt    <= '0;
            cmd_sr     <= '0;
            cnt        <= '0;
            sel_oh     <= '0;
            sh_mosi    <= '0;
            sh_miso    <= '0;
            sh_bits    <= '0;
            frame_done <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: pulses default low here so every branch below only has to raise them.
            frame_done <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: if (ss_fall) begin
                    cmd_cnt <= '0;
                    state   <= CMD;
                end
                CMD: if (ss_rise) begin
                    state <= IDLE;
                end else if (sck_rise) begin
                    cmd_sr  <= {cmd_sr[6:0], mosi_s};
                    cmd_cnt <= cmd_cnt + 3'd1;
                    if (cmd_cnt == 3'd7) state <= DECODE;
                end
                DECODE: if (ss_rise) begin
                    state <= IDLE;
                end else if (sck_fall) begin
                    if (code_ok) begin
                        sel_oh  <= NUM_DEV'(1) << (cmd_sr - 8'd1);
                        sh_mosi <= '0;
                        sh_miso <= '0;
                        sh_bits <= '0;
                        state   <= ACTIVE;
                    end else begin
                        err_q <= 1'b1;
                        state <= DROP;
                    end
                end
                DROP: if (ss_rise) begin
                    cnt   <= '0;
                    state <= GAP;
                end
                ACTIVE: if (ss_rise) begin
                    frame_done <= 1'b1;
                    cnt        <= '0;
                    state      <= (|(LDAC_MASK & sel_oh)) ? LDAC : GAP;
                end else if (sck_rise) begin
                    sh_mosi <= {sh_mosi[CAP_W-2:0], mosi_s};
                    sh_miso <= {sh_miso[CAP_W-2:0], miso_sel};
                    if (sh_bits != 16'hFFFF) sh_bits <= sh_bits + 16'd1;
                end
                // Count 0 lines up with cap_valid; the strobe is low for counts 1..LDAC_CYCLES.
                LDAC: if (cnt == 16'(LDAC_CYCLES)) begin
                    cnt   <= '0;
                    state <= GAP;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                GAP: if (cnt == 16'(GAP_CYCLES - 1)) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage trails the FSM by one cycle so pins change at sample edge + 3.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            dev_cs_n   <= '1;
            dev_ldac_n <= '1;
            active     <= 1'b0;
            cap_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            cap_dev    <= '0;
            cap_mosi   <= '0;
            cap_miso   <= '0;
            cap_bits   <= '0;
        end else begin
            dev_cs_n   <= (state == ACTIVE) ? ~sel_oh : '1;
            dev_ldac_n <= (state == LDAC && cnt != 16'd0) ? ~sel_oh : '1;
            active     <= (state == ACTIVE);
            cap_valid  <= frame_done;
            cmd_err    <= err_q;
            if (frame_done) begin
                cap_dev  <= cmd_sr;
                cap_mosi <= sh_mosi;
                cap_miso <= sh_miso;
                cap_bits <= sh_bits;
            end
        end
    end

    assign dev_sck   = host_sclk & active;
    assign dev_mosi  = host_mosi;
    assign host_miso = active & miso_sel;

endmodule
